// File: rtl/rv32_pkg.sv
//==============================================================================
// Module      : rv32_pkg
// Description : Shared RV32I core widths, memory constants and fetch FSM state.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package rv32_pkg;

   localparam int XLEN = 32;
   localparam int ILEN = 32;

   localparam logic [3:0]      IMEM_MASK_WORD   = 4'b1111;
   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_FLUSH = 2'd2
   } fetch_state_t;

   // Sequential fetch address; wraps modulo 2^XLEN.
   function automatic logic [XLEN-1:0] next_fetch_pc(input logic [XLEN-1:0] pc);
      return pc + XLEN'(4);
   endfunction

endpackage

`default_nettype wire

// File: rtl/ifetch_fifo.sv
//==============================================================================
// Module      : ifetch_fifo
// Description : Circular instruction buffer with count and synchronous clear.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ifetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty
);

   localparam int c_aw = $clog2(DEPTH);
   localparam int c_cw = c_aw + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_aw-1:0]  r_wr_ptr;
   logic [c_aw-1:0]  r_rd_ptr;
   logic [c_cw-1:0]  r_count;
   logic [c_cw-1:0]  w_count_nxt;

   assign w_count_nxt = r_count + c_cw'(wr_en) - c_cw'(rd_en);

   // Storage is reset too so the head reads as zero out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (wr_en) begin
            r_mem[r_wr_ptr] <= wr_data;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (rd_en) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         r_count <= w_count_nxt;
      end
   end

   assign rd_data = r_mem[r_rd_ptr];
   assign count   = r_count;
   assign empty   = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/ifetch_unit.sv
//==============================================================================
// Module      : ifetch_unit
// Description : RV32I fetch stage: PC, single-outstanding imem requests, queue.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ifetch_unit
   import rv32_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int              DEPTH    = 2
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   output logic [3:0]      imem_mask,
   output logic            imem_we_re,
   input  logic            imem_valid,
   input  logic [ILEN-1:0] imem_rdata,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [ILEN-1:0] if_instr,
   output logic [XLEN-1:0] if_pc,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            fetch_misaligned
);

   localparam int c_cw      = $clog2(DEPTH) + 1;
   localparam int c_entry_w = ILEN + XLEN;

   fetch_state_t          r_state;
   fetch_state_t          w_state_nxt;
   logic [XLEN-1:0]       r_pc;
   logic [XLEN-1:0]       r_req_pc;
   logic                  r_misaligned;

   logic                  w_push;
   logic                  w_pop;
   logic                  w_space;
   logic                  w_can_issue;
   logic [c_cw:0]         w_occ_nxt;
   logic [c_cw-1:0]       w_fifo_count;
   logic                  w_fifo_empty;
   logic [c_entry_w-1:0]  w_head;

   assign w_pop  = if_valid & if_ready;
   assign w_push = (r_state == S_WAIT) & imem_valid & ~redirect_valid;

   // Occupancy after this edge must leave room for the response of a new request.
   assign w_occ_nxt   = {1'b0, w_fifo_count} + (c_cw + 1)'(w_push) - (c_cw + 1)'(w_pop);
   assign w_space     = (w_occ_nxt < (c_cw + 1)'(DEPTH));
   assign w_can_issue = ~redirect_valid & ~r_misaligned & w_space;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      imem_req    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_can_issue) begin
               imem_req    = 1'b1;
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_valid) begin
               if (w_can_issue) begin
                  imem_req    = 1'b1;
                  w_state_nxt = S_WAIT;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         S_FLUSH: begin
            if (imem_valid) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
      // A redirect with the response still in flight must swallow that response.
      if (redirect_valid && (r_state == S_WAIT)) begin
         w_state_nxt = imem_valid ? S_IDLE : S_FLUSH;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc         <= RESET_PC;
         r_req_pc     <= '0;
         r_misaligned <= 1'b0;
      end else if (redirect_valid) begin
         r_pc         <= redirect_pc;
         r_misaligned <= (redirect_pc[1:0] != 2'b00);
      end else if (imem_req) begin
         r_pc     <= next_fetch_pc(r_pc);
         r_req_pc <= r_pc;
      end
   end

   ifetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (c_entry_w)
   ) u_queue (
      .clk     (clk),
      .rst     (rst),
      .clr     (redirect_valid),
      .wr_en   (w_push),
      .wr_data ({imem_rdata, r_req_pc}),
      .rd_en   (w_pop),
      .rd_data (w_head),
      .count   (w_fifo_count),
      .empty   (w_fifo_empty)
   );

   assign if_valid         = ~w_fifo_empty;
   assign if_instr         = w_head[c_entry_w-1:XLEN];
   assign if_pc            = w_head[XLEN-1:0];
   assign imem_addr        = r_pc;
   assign imem_mask        = IMEM_MASK_WORD;
   assign imem_we_re       = 1'b0;
   assign fetch_misaligned = r_misaligned;

endmodule

`default_nettype wire

// File: tb/tb_ifetch_unit.sv
//==============================================================================
// Module      : tb_ifetch_unit
// Description : Directed self-checking bench for ifetch_unit with latency model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ifetch_unit;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [3:0]  imem_mask;
   logic        imem_we_re;
   logic        imem_valid;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        fetch_misaligned;

   int n_vec  = 0;
   int n_miss = 0;

   // Memory model state
   int          lat     = 1;
   logic        pend    = 1'b0;
   int          rem     = 0;
   logic [31:0] paddr   = '0;
   logic        nxt_valid = 1'b0;
   logic [31:0] nxt_data  = '0;
   int          req_cnt = 0;

   ifetch_unit #(
      .RESET_PC (32'h0000_0000),
      .DEPTH    (2)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .imem_req         (imem_req),
      .imem_addr        (imem_addr),
      .imem_mask        (imem_mask),
      .imem_we_re       (imem_we_re),
      .imem_valid       (imem_valid),
      .imem_rdata       (imem_rdata),
      .if_valid         (if_valid),
      .if_ready         (if_ready),
      .if_instr         (if_instr),
      .if_pc            (if_pc),
      .redirect_valid   (redirect_valid),
      .redirect_pc      (redirect_pc),
      .fetch_misaligned (fetch_misaligned)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return 32'h0000_0013 + (a >> 2) * 32'h0000_0100;
   endfunction

   // Memory ignores requests seen during core reset but lets in-flight ones complete.
   always @(negedge clk) begin
      nxt_valid = 1'b0;
      if (!rst && imem_req) begin
         pend    = 1'b1;
         rem     = lat;
         paddr   = imem_addr;
         req_cnt = req_cnt + 1;
      end else if (pend) begin
         rem = rem - 1;
      end
      if (pend && rem <= 1) begin
         nxt_valid = 1'b1;
         nxt_data  = word_at(paddr);
         pend      = 1'b0;
      end
   end

   always @(posedge clk) begin
      #1;
      imem_valid = nxt_valid;
      imem_rdata = nxt_valid ? nxt_data : 32'h0;
   end

   task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec = n_vec + 1;
      if (obs !== exp) begin
         n_miss = n_miss + 1;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   // Leaves the bench at the start of cycle 0, the first cycle with rst low.
   task automatic do_reset(input int l, input logic rdy);
      rst            = 1'b1;
      lat            = l;
      if_ready       = rdy;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      repeat (4) next_cycle();
      sample();
      check_vec("rst_if_valid", {31'b0, if_valid}, 32'h0);
      check_vec("rst_if_instr", if_instr, 32'h0);
      check_vec("rst_if_pc", if_pc, 32'h0);
      check_vec("rst_misaligned", {31'b0, fetch_misaligned}, 32'h0);
      check_vec("rst_mask_we", {27'b0, imem_mask, imem_we_re}, 32'h0000_001E);
      next_cycle();
      rst     = 1'b0;
      req_cnt = 0;
   endtask

   logic [31:0] seq_instr [3] = '{32'h0000_0013, 32'h0000_0113, 32'h0000_0213};
   logic [31:0] seq_addr  [3] = '{32'h0000_0000, 32'h0000_0004, 32'h0000_0008};

   initial begin
      rst            = 1'b1;
      if_ready       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      imem_valid     = 1'b0;
      imem_rdata     = 32'h0;

      // Streaming, L=1, decode always ready
      do_reset(1, 1'b1);
      for (int c = 0; c <= 4; c++) begin
         sample();
         if (c <= 2) begin
            check_vec("stream_req", {31'b0, imem_req}, 32'h1);
            check_vec("stream_addr", imem_addr, seq_addr[c]);
         end
         if (c >= 2) begin
            check_vec("stream_if_valid", {31'b0, if_valid}, 32'h1);
            check_vec("stream_if_pc", if_pc, seq_addr[c-2]);
            check_vec("stream_if_instr", if_instr, seq_instr[c-2]);
         end
         next_cycle();
      end

      // Back-pressure, L=1, decode stalled
      do_reset(1, 1'b0);
      for (int c = 0; c <= 5; c++) begin
         sample();
         if (c >= 3) begin
            check_vec("stall_req", {31'b0, imem_req}, 32'h0);
            check_vec("stall_if_valid", {31'b0, if_valid}, 32'h1);
            check_vec("stall_if_pc", if_pc, 32'h0);
         end
         next_cycle();
      end
      check_vec("stall_req_count", req_cnt, 32'd2);
      if_ready = 1'b1;
      sample();
      check_vec("resume_req", {31'b0, imem_req}, 32'h1);
      check_vec("resume_addr", imem_addr, 32'h0000_0008);
      check_vec("resume_instr0", if_instr, 32'h0000_0013);
      next_cycle();
      sample();
      check_vec("resume_pc1", if_pc, 32'h0000_0004);
      check_vec("resume_instr1", if_instr, 32'h0000_0113);
      next_cycle();

      // Redirect with a response in flight, L=3
      do_reset(3, 1'b1);
      for (int c = 0; c <= 14; c++) begin
         redirect_valid = (c == 7);
         redirect_pc    = 32'h0000_0040;
         sample();
         if (c == 6) check_vec("flush_pre_addr", imem_addr, 32'h0000_0008);
         if (c == 7) check_vec("flush_pre_pc", if_pc, 32'h0000_0004);
         if (c == 8 || c == 9) begin
            check_vec("flush_if_valid", {31'b0, if_valid}, 32'h0);
            check_vec("flush_no_req", {31'b0, imem_req}, 32'h0);
         end
         if (c == 10) begin
            check_vec("flush_req", {31'b0, imem_req}, 32'h1);
            check_vec("flush_addr", imem_addr, 32'h0000_0040);
         end
         if (c == 14) begin
            check_vec("flush_if_valid_new", {31'b0, if_valid}, 32'h1);
            check_vec("flush_if_pc", if_pc, 32'h0000_0040);
            check_vec("flush_if_instr", if_instr, 32'h0000_1013);
         end
         next_cycle();
      end
      redirect_valid = 1'b0;

      // Misaligned redirect blocks fetch until an aligned redirect
      do_reset(1, 1'b1);
      for (int c = 0; c <= 6; c++) begin
         redirect_valid = (c == 0) || (c == 3);
         redirect_pc    = (c == 0) ? 32'h0000_0042 : 32'h0000_0080;
         sample();
         if (c == 1 || c == 2) begin
            check_vec("mis_flag", {31'b0, fetch_misaligned}, 32'h1);
            check_vec("mis_no_req", {31'b0, imem_req}, 32'h0);
         end
         if (c == 4) begin
            check_vec("mis_clear", {31'b0, fetch_misaligned}, 32'h0);
            check_vec("mis_req", {31'b0, imem_req}, 32'h1);
            check_vec("mis_addr", imem_addr, 32'h0000_0080);
         end
         if (c == 6) begin
            check_vec("mis_if_pc", if_pc, 32'h0000_0080);
            check_vec("mis_if_instr", if_instr, 32'h0000_2013);
         end
         next_cycle();
      end
      redirect_valid = 1'b0;

      // PC wrap at the top of the address space
      do_reset(1, 1'b1);
      for (int c = 0; c <= 4; c++) begin
         redirect_valid = (c == 0);
         redirect_pc    = 32'hFFFF_FFFC;
         sample();
         if (c == 1) check_vec("wrap_addr_hi", imem_addr, 32'hFFFF_FFFC);
         if (c == 2) begin
            check_vec("wrap_req", {31'b0, imem_req}, 32'h1);
            check_vec("wrap_addr_lo", imem_addr, 32'h0000_0000);
         end
         if (c == 3) begin
            check_vec("wrap_if_pc_hi", if_pc, 32'hFFFF_FFFC);
            check_vec("wrap_if_instr_hi", if_instr, 32'hFFFF_FF13);
         end
         if (c == 4) check_vec("wrap_if_pc_lo", if_pc, 32'h0000_0000);
         next_cycle();
      end
      redirect_valid = 1'b0;

      // Reset while waiting with one queued instruction, L=3
      do_reset(3, 1'b0);
      for (int c = 0; c <= 4; c++) begin
         sample();
         if (c == 3) check_vec("arst_pre_addr", imem_addr, 32'h0000_0004);
         if (c == 4) begin
            check_vec("arst_pre_valid", {31'b0, if_valid}, 32'h1);
            check_vec("arst_pre_pc", if_pc, 32'h0000_0000);
         end
         next_cycle();
      end
      rst = 1'b1;
      sample();
      check_vec("arst_if_valid", {31'b0, if_valid}, 32'h0);
      check_vec("arst_if_instr", if_instr, 32'h0);
      next_cycle();
      rst = 1'b0;
      sample();
      check_vec("arst_first_req", {31'b0, imem_req}, 32'h1);
      check_vec("arst_first_addr", imem_addr, 32'h0000_0000);
      for (int c = 7; c <= 10; c++) begin
         next_cycle();
         sample();
         if (c == 7 || c == 8) begin
            check_vec("arst_late_dropped", {31'b0, if_valid}, 32'h0);
            check_vec("arst_wait_no_req", {31'b0, imem_req}, 32'h0);
         end
         if (c == 10) begin
            check_vec("arst_if_valid_new", {31'b0, if_valid}, 32'h1);
            check_vec("arst_if_pc_new", if_pc, 32'h0000_0000);
            check_vec("arst_if_instr_new", if_instr, 32'h0000_0013);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

`default_nettype wire

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch stage of the RV32I core. Owns the program counter, issues single-outstanding word requests to instruction memory over a request/valid handshake, and buffers returned instructions with their PCs in a small queue that the decode stage drains under a valid/ready handshake. It takes PC redirects from execute (branch, JAL, JALR), flushing queued and in-flight instructions.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset
- DEPTH, 2, instruction queue entries (power of two, ≥2)

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- imem_req  out  1  request strobe, one cycle per request
- imem_addr  out  32  byte address of request, valid when imem_req=1
- imem_mask  out  4  constant 4'b1111 (word fetch)
- imem_we_re  out  1  constant 0 (read)
- imem_valid  in  1  response strobe for the outstanding request
- imem_rdata  in  32  instruction word, valid with imem_valid
- if_valid  out  1  queue head holds an instruction
- if_ready  in  1  decode accepts head this cycle
- if_instr  out  32  head instruction
- if_pc  out  32  head instruction address
- redirect_valid  in  1  execute requests new fetch PC
- redirect_pc  in  32  new fetch PC
- fetch_misaligned  out  1  sticky: last redirect target had pc[1:0]≠0

## Operation
- Registers: pc, req_pc (address of outstanding request), state, queue (DEPTH × {instr, pc}), count, misaligned flag.
- States: S_IDLE (nothing outstanding), S_WAIT (one request outstanding), S_FLUSH (outstanding response to discard).
- space = (count + push − pop) < DEPTH, where push = response written this cycle, pop = if_valid & if_ready.
- imem_req = !redirect_valid & !fetch_misaligned & space & (state==S_IDLE | (state==S_WAIT & imem_valid)). Combinational path imem_valid→imem_req is intended.
- On issue: imem_addr=pc, req_pc←pc, pc←pc+4 (mod 2^32, wraps to 0), state←S_WAIT.
- S_WAIT & imem_valid & !redirect_valid: push {imem_rdata, req_pc}; state←S_WAIT if re-issued, else S_IDLE.
- S_FLUSH & imem_valid: discard, state←S_IDLE. imem_valid in S_IDLE ignored.
- redirect_valid (any state, highest priority): queue cleared (count←0, if_valid low next cycle), pc←redirect_pc, no issue this cycle; S_WAIT without imem_valid → S_FLUSH; S_WAIT with imem_valid → response dropped, S_IDLE; S_IDLE/S_FLUSH unchanged (S_FLUSH still awaits its response).
- fetch_misaligned←(redirect_pc[1:0]≠0) on every redirect; while set, no requests issued.
- Push and pop in same cycle with count==DEPTH never occurs (space rule); count==0 pop impossible (if_valid=0).

## Timing
- Reset values: pc=RESET_PC, state=S_IDLE, count=0, if_valid=0, if_instr=0, if_pc=0, fetch_misaligned=0; imem_req evaluates to 1 in the first cycle after rst deasserts.
- Response latency L≥1 cycles after imem_req. Throughput with if_ready=1: one instruction per L cycles.
- Queue has no bypass: instruction pushed at edge N is on if_instr/if_pc with if_valid=1 in cycle after edge N.
- Redirect at edge N: first request to redirect_pc in the cycle after edge N if S_IDLE, else in the cycle the flushed response arrives plus one.

## Structure
- Package rv32_pkg: XLEN=32, ILEN=32, IMEM_MASK_WORD=4'b1111, fetch state enum, default RESET_PC.
- Sub-module ifetch_fifo (DEPTH, WIDTH=64): circular buffer with rd/wr pointers, count, synchronous clear; ifetch_unit holds PC, FSM and issue logic.

## Test plan
- Reset release, L=1 memory with word k = 0x0000_0013+k·0x100, if_ready=1 → imem_addr 0x0,0x4,0x8 on consecutive cycles; if_pc 0x0,0x4,0x8 with matching if_instr one per cycle.
- if_ready=0 from reset, L=1 → exactly 2 requests (0x0,0x4), if_valid=1, imem_req stays 0; raise if_ready → pops resume, next request 0x8.
- L=3, redirect_pc=0x40 one cycle after request to 0x8 → response for 0x8 dropped, queue empty, next imem_addr=0x40 cycle after that response; if_pc 0x40 next.
- Redirect to 0x42 → fetch_misaligned=1, no imem_req; redirect to 0x80 → flag clears, request 0x80.
- PC 0xFFFF_FFFC via redirect → requests 0xFFFF_FFFC then 0x0000_0000.
- Assert rst during S_WAIT with count=1 → if_valid=0 immediately, late imem_valid ignored, first request RESET_PC after release.
